// File: rtl/pfb_sequencer_if.sv
// Control/coefficient/tagging bus between the polyphase filter sequencer and its surroundings.
// master drives requests and coefficient writes; slave is the sequencer.
interface pfb_sequencer_if #(
    parameter int unsigned NOF_CHANNELS = 2,
    parameter int unsigned NOF_TAPS     = 2,
    parameter int unsigned COEFF_WIDTH  = 16
);
    localparam int unsigned CHAN_W = $clog2(NOF_CHANNELS);
    localparam int unsigned ADDR_W = $clog2(NOF_CHANNELS * NOF_TAPS);

    logic                   enable;
    logic                   in_valid;
    logic                   coeff_wr_en;
    logic [ADDR_W-1:0]      coeff_wr_addr;
    logic [COEFF_WIDTH-1:0] coeff_wr_data;
    logic                   coeff_wr_ready;
    logic                   filt_valid;
    logic [COEFF_WIDTH-1:0] coeff_a;
    logic [COEFF_WIDTH-1:0] coeff_b;
    logic                   out_valid;
    logic                   out_sop;
    logic                   out_eop;
    logic [CHAN_W-1:0]      out_chan;
    logic                   busy;

    modport master (
        output enable, in_valid, coeff_wr_en, coeff_wr_addr, coeff_wr_data,
        input  coeff_wr_ready, filt_valid, coeff_a, coeff_b,
               out_valid, out_sop, out_eop, out_chan, busy
    );

    modport slave (
        input  enable, in_valid, coeff_wr_en, coeff_wr_addr, coeff_wr_data,
        output coeff_wr_ready, filt_valid, coeff_a, coeff_b,
               out_valid, out_sop, out_eop, out_chan, busy
    );
endinterface

// File: rtl/pfb_sequencer.sv
// Sequencer and coefficient store for one polyphase filter branch: gates samples, supplies per-channel
// coefficients and tags filter outputs once the tap delay lines hold valid history.
// COEFF_DELAY and OUT_DELAY must both be >= 2, with COEFF_DELAY <= OUT_DELAY.
module pfb_sequencer #(
    parameter int unsigned NOF_CHANNELS = 2,
    parameter int unsigned NOF_TAPS     = 2,
    parameter int unsigned COEFF_WIDTH  = 16,
    parameter int unsigned COEFF_DELAY  = 2,
    parameter int unsigned OUT_DELAY    = 4
) (
    input  logic           clk_data,
    input  logic           rst_n,
    pfb_sequencer_if.slave bus
);
    localparam int unsigned CHAN_W    = $clog2(NOF_CHANNELS);
    localparam int unsigned MEM_DEPTH = NOF_CHANNELS * NOF_TAPS;
    localparam int unsigned ADDR_W    = $clog2(MEM_DEPTH);
    localparam int unsigned FRAME_W   = $clog2(NOF_TAPS + 1);
    localparam int unsigned OPIPE_N   = OUT_DELAY - 1;
    localparam int unsigned CFRONT    = COEFF_DELAY - 2;

    localparam logic [CHAN_W-1:0]  LAST_CHAN  = CHAN_W'(NOF_CHANNELS - 1);
    localparam logic [FRAME_W-1:0] FRAME_FULL = FRAME_W'(NOF_TAPS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    typedef struct packed {
        logic              acc;   // a sample was accepted
        logic              tagv;  // that sample produces a valid filter output
        logic [CHAN_W-1:0] chan;
    } tag_t;

    state_e                 state_q, state_d;
    logic [CHAN_W-1:0]      chan_q, chan_d;
    logic [FRAME_W-1:0]     frame_q, frame_d;
    logic [COEFF_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [COEFF_WIDTH-1:0] mem_d [MEM_DEPTH];
    tag_t                   opipe_q [OPIPE_N];
    tag_t                   opipe_d [OPIPE_N];
    tag_t                   out_q, out_d;
    logic                   out_sop_q, out_sop_d;
    logic                   out_eop_q, out_eop_d;
    logic [COEFF_WIDTH-1:0] coeff_a_q, coeff_a_d;
    logic [COEFF_WIDTH-1:0] coeff_b_q, coeff_b_d;
    logic                   wr_ready_q, wr_ready_d;
    logic                   busy_q, busy_d;

    logic                   accept_c;
    logic                   addr_ok_c;
    tag_t                   tag_c;

    assign accept_c  = bus.in_valid && (state_q != ST_IDLE);
    assign addr_ok_c = 32'(bus.coeff_wr_addr) < MEM_DEPTH;

    // Mode control plus channel/frame counters
    always_comb begin : p_fsm
        state_d = state_q;
        chan_d  = chan_q;
        frame_d = frame_q;

        if (accept_c) begin
            chan_d = chan_q + CHAN_W'(1);
            if ((chan_q == LAST_CHAN) && (frame_q != FRAME_FULL)) begin
                frame_d = frame_q + FRAME_W'(1);
            end
        end

        // Leaving WARMUP/RUN waits for the frame to close unless it is already closed
        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_d = ST_WARMUP;
                    chan_d  = '0;
                    frame_d = '0;
                end
            end
            ST_WARMUP: begin
                if (!bus.enable) begin
                    state_d = (chan_d == '0) ? ST_IDLE : ST_DRAIN;
                end else if (frame_d == FRAME_FULL) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.enable) begin
                    state_d = (chan_d == '0) ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (chan_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Tag pipeline; its early stages also time the coefficient fetch
    always_comb begin : p_pipe
        tag_c.acc  = accept_c;
        tag_c.tagv = accept_c && (frame_q == FRAME_FULL);
        tag_c.chan = chan_q;

        opipe_d[0] = tag_c;
        for (int unsigned i = 1; i < OPIPE_N; i++) begin
            opipe_d[i] = opipe_q[i-1];
        end

        out_d = opipe_q[OPIPE_N-1];
        if (!out_d.tagv) begin
            out_d.chan = '0;
        end
        out_sop_d = out_d.tagv && (out_d.chan == '0);
        out_eop_d = out_d.tagv && (out_d.chan == LAST_CHAN);

        busy_d = (state_d != ST_IDLE) || out_d.acc;
        for (int unsigned i = 0; i < OPIPE_N; i++) begin
            busy_d = busy_d || opipe_d[i].acc;
        end
        wr_ready_d = (state_d == ST_IDLE);
    end

    // Coefficient fetch; holds the last pair between samples
    always_comb begin : p_coeff
        coeff_a_d = coeff_a_q;
        coeff_b_d = coeff_b_q;
        if (opipe_q[CFRONT].acc) begin
            coeff_a_d = mem_q[ADDR_W'(opipe_q[CFRONT].chan)];
            coeff_b_d = mem_q[ADDR_W'(NOF_CHANNELS) + ADDR_W'(opipe_q[CFRONT].chan)];
        end
    end

    // Coefficient store; writes only land while idle
    always_comb begin : p_mem
        mem_d = mem_q;
        if (bus.coeff_wr_en && wr_ready_q && addr_ok_c) begin
            mem_d[bus.coeff_wr_addr] = bus.coeff_wr_data;
        end
    end

    always_ff @(posedge clk_data or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            chan_q     <= '0;
            frame_q    <= '0;
            out_q      <= '0;
            out_sop_q  <= 1'b0;
            out_eop_q  <= 1'b0;
            coeff_a_q  <= '0;
            coeff_b_q  <= '0;
            wr_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            for (int unsigned i = 0; i < OPIPE_N; i++) begin
                opipe_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            frame_q    <= frame_d;
            out_q      <= out_d;
            out_sop_q  <= out_sop_d;
            out_eop_q  <= out_eop_d;
            coeff_a_q  <= coeff_a_d;
            coeff_b_q  <= coeff_b_d;
            wr_ready_q <= wr_ready_d;
            busy_q     <= busy_d;
            mem_q      <= mem_d;
            opipe_q    <= opipe_d;
        end
    end

    assign bus.filt_valid     = accept_c;
    assign bus.coeff_wr_ready = wr_ready_q;
    assign bus.coeff_a        = coeff_a_q;
    assign bus.coeff_b        = coeff_b_q;
    assign bus.out_valid      = out_q.tagv;
    assign bus.out_sop        = out_sop_q;
    assign bus.out_eop        = out_eop_q;
    assign bus.out_chan       = out_q.chan;
    assign bus.busy           = busy_q;

endmodule
